bios_wd_lpc_target: RTL and testbench

BIOS_WD_LPC_TARGET -- requirements
Module: bios_wd_lpc_target

---
 rtl/bios_wd_lpc_target.sv | 183 ++++++++++++++++++
 tb/tb_bios_wd_lpc_target.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bios_wd_lpc_target.sv
// LPC I/O target exposing the BIOS watchdog control register at BIOS_WD_ADDR and a status
// register at BIOS_WD_ADDR+1. Only single-cycle SYNC is used.
module bios_wd_lpc_target #(
  parameter logic [15:0] BIOS_WD_ADDR = 16'h0810
) (
  input  logic       LpcClock,
  input  logic       Reset,
  input  logic       LFRAMEn,
  input  logic [3:0] LAD_in,
  output logic [3:0] LAD_out,
  output logic       LAD_oe,
  input  logic       BiosFinished,
  input  logic       BiosPowerOff,
  input  logic       ForceSwap,
  output logic [7:0] BiosRegister,
  output logic       WriteBiosWD
);

  localparam logic [15:0] CtlAddr = BIOS_WD_ADDR;
  localparam logic [15:0] StsAddr = BIOS_WD_ADDR + 16'd1;

  typedef enum logic [3:0] {
    StIdle, StStart, StAddr0, StAddr1, StAddr2, StAddr3, StWdata0, StWdata1,
    StTar0, StTar1, StSync, StRdata0, StRdata1, StTar2, StTar3
  } state_e;

  state_e      state_q, state_d;
  logic        is_write_q, is_write_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [3:0]  lad_out_q, lad_out_d;
  logic        lad_oe_q, lad_oe_d;
  logic [7:0]  bios_reg_q, bios_reg_d;
  logic        wr_strobe_q, wr_strobe_d;
  logic        swap_seen_q, swap_seen_d;
  logic        commit;
  logic        addr_hit;
  logic [7:0]  rdata;

  assign addr_hit = ({addr_q[15:4], LAD_in} == CtlAddr) || ({addr_q[15:4], LAD_in} == StsAddr);
  assign rdata    = (addr_q == CtlAddr) ? bios_reg_q
                                        : {5'b0, swap_seen_q, BiosPowerOff, BiosFinished};

  always_comb begin
    state_d    = state_q;
    is_write_d = is_write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    commit     = 1'b0;
    if (!LFRAMEn && state_q != StIdle && state_q != StStart) begin
      // Host abort: drop the cycle, possibly straight into a new START.
      state_d = (LAD_in == 4'h0) ? StStart : StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (!LFRAMEn && LAD_in == 4'h0) state_d = StStart;
        end
        StStart: begin
          if (LFRAMEn) begin
            if (LAD_in == 4'h0) begin
              is_write_d = 1'b0;
              state_d    = StAddr0;
            end else if (LAD_in == 4'h2) begin
              is_write_d = 1'b1;
              state_d    = StAddr0;
            end else begin
              state_d = StIdle;
            end
          end else if (LAD_in != 4'h0) begin
            state_d = StIdle;
          end
        end
        StAddr0: begin
          addr_d[15:12] = LAD_in;
          state_d       = StAddr1;
        end
        StAddr1: begin
          addr_d[11:8] = LAD_in;
          state_d      = StAddr2;
        end
        StAddr2: begin
          addr_d[7:4] = LAD_in;
          state_d     = StAddr3;
        end
        StAddr3: begin
          addr_d[3:0] = LAD_in;
          if (!addr_hit)       state_d = StIdle;
          else if (is_write_q) state_d = StWdata0;
          else                 state_d = StTar0;
        end
        StWdata0: begin
          wdata_d[3:0] = LAD_in;
          state_d      = StWdata1;
        end
        StWdata1: begin
          wdata_d[7:4] = LAD_in;
          state_d      = StTar0;
        end
        StTar0:   state_d = StTar1;
        StTar1: begin
          state_d = StSync;
          commit  = is_write_q;
        end
        StSync:   state_d = is_write_q ? StTar2 : StRdata0;
        StRdata0: state_d = StRdata1;
        StRdata1: state_d = StTar2;
        StTar2:   state_d = StTar3;
        StTar3:   state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  // LAD drive is a function of the next state so the pins come straight from flops.
  always_comb begin
    lad_out_d = 4'hF;
    lad_oe_d  = 1'b0;
    case (state_d)
      StSync: begin
        lad_out_d = 4'h0;
        lad_oe_d  = 1'b1;
      end
      StRdata0: begin
        lad_out_d = rdata[3:0];
        lad_oe_d  = 1'b1;
      end
      StRdata1: begin
        lad_out_d = rdata[7:4];
        lad_oe_d  = 1'b1;
      end
      StTar2: begin
        lad_out_d = 4'hF;
        lad_oe_d  = 1'b1;
      end
      default: begin
        lad_out_d = 4'hF;
        lad_oe_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    bios_reg_d  = bios_reg_q;
    wr_strobe_d = 1'b0;
    swap_seen_d = swap_seen_q;
    if (commit && addr_q == CtlAddr) begin
      bios_reg_d  = wdata_q;
      wr_strobe_d = 1'b1;
    end
    if (commit && addr_q == StsAddr && wdata_q[2]) swap_seen_d = 1'b0;
    if (ForceSwap) swap_seen_d = 1'b1;
  end

  always_ff @(posedge LpcClock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= StIdle;
      is_write_q  <= 1'b0;
      addr_q      <= 16'h0000;
      wdata_q     <= 8'h00;
      lad_out_q   <= 4'hF;
      lad_oe_q    <= 1'b0;
      bios_reg_q  <= 8'h00;
      wr_strobe_q <= 1'b0;
      swap_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_write_q  <= is_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      lad_out_q   <= lad_out_d;
      lad_oe_q    <= lad_oe_d;
      bios_reg_q  <= bios_reg_d;
      wr_strobe_q <= wr_strobe_d;
      swap_seen_q <= swap_seen_d;
    end
  end

  assign LAD_out      = lad_out_q;
  assign LAD_oe       = lad_oe_q;
  assign BiosRegister = bios_reg_q;
  assign WriteBiosWD  = wr_strobe_q;

endmodule

// File: tb/tb_bios_wd_lpc_target.sv
// Randomized bench for bios_wd_lpc_target: a transaction-level register model queues the
// expected write strobes and LAD drive frames; a negedge monitor pops and compares them.
module tb_bios_wd_lpc_target;

  localparam logic [15:0] Base = 16'h0810;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       LFRAMEn;
  logic [3:0] LAD_in;
  logic [3:0] LAD_out;
  logic       LAD_oe;
  logic       BiosFinished;
  logic       BiosPowerOff;
  logic       ForceSwap;
  logic [7:0] BiosRegister;
  logic       WriteBiosWD;

  bios_wd_lpc_target #(.BIOS_WD_ADDR(Base)) dut (
    .LpcClock    (clk),
    .Reset       (rst_n),
    .LFRAMEn     (LFRAMEn),
    .LAD_in      (LAD_in),
    .LAD_out     (LAD_out),
    .LAD_oe      (LAD_oe),
    .BiosFinished(BiosFinished),
    .BiosPowerOff(BiosPowerOff),
    .ForceSwap   (ForceSwap),
    .BiosRegister(BiosRegister),
    .WriteBiosWD (WriteBiosWD)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          len;
    logic [15:0] nib;
  } frame_t;

  frame_t     exp_bus[$];
  logic [7:0] exp_wr[$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] m_bios;
  logic       m_swap;

  // Monitor: strobe events and contiguous LAD drive frames.
  int          flen = 0;
  logic [15:0] fnib = 16'h0;
  always @(negedge clk) begin
    if (!rst_n) begin
      flen = 0;
      fnib = 16'h0;
    end else begin
      if (WriteBiosWD) begin
        checks++;
        if (exp_wr.size() == 0) begin
          errors++;
          $display("FAIL wr_strobe: unexpected strobe, BiosRegister=%h", BiosRegister);
        end else begin
          logic [7:0] e;
          e = exp_wr.pop_front();
          if (BiosRegister !== e || LAD_oe !== 1'b1 || LAD_out !== 4'h0) begin
            errors++;
            $display("FAIL wr_strobe: got reg=%h oe=%b lad=%h expected reg=%h oe=1 lad=0",
                     BiosRegister, LAD_oe, LAD_out, e);
          end
        end
      end
      if (LAD_oe === 1'b1) begin
        fnib = {fnib[11:0], LAD_out};
        flen++;
      end else if (flen > 0) begin
        checks++;
        if (exp_bus.size() == 0) begin
          errors++;
          $display("FAIL bus_frame: unexpected drive len=%0d nib=%h", flen, fnib);
        end else begin
          frame_t f;
          f = exp_bus.pop_front();
          if (f.len != flen || f.nib !== fnib) begin
            errors++;
            $display("FAIL bus_frame: got len=%0d nib=%h expected len=%0d nib=%h",
                     flen, fnib, f.len, f.nib);
          end
        end
        flen = 0;
        fnib = 16'h0;
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fr, input logic [3:0] lad);
    LFRAMEn = fr;
    LAD_in  = lad;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b1, 4'hF);
  endtask

  task automatic pulse_swap();
    ForceSwap = 1'b1;
    drive(1'b1, 4'hF);
    ForceSwap = 1'b0;
    m_swap = 1'b1;
  endtask

  // One LPC cycle. abort_at/stop_after < 0 mean "never".
  task automatic lpc(input logic [3:0] ctype, input logic [15:0] addr, input logic [7:0] data,
                     input int abort_at, input logic [3:0] abort_lad, input bit skip_start,
                     input bit swap_at_commit, input int stop_after);
    logic [3:0] nib [13];
    logic       fr  [13];
    bit         wr, rd, hit_ctl, hit_sts, full;
    int         commit_idx;
    logic [7:0] rb;
    frame_t     f;
    wr         = (ctype == 4'h2);
    rd         = (ctype == 4'h0);
    commit_idx = wr ? 9 : 7;
    hit_ctl    = (addr == Base);
    hit_sts    = (addr == Base + 16'd1);
    full       = (abort_at < 0 || abort_at > commit_idx) && stop_after < 0;

    // Reference model at transaction level.
    if (full && rd && (hit_ctl || hit_sts)) begin
      rb    = hit_ctl ? m_bios : {5'b0, m_swap, BiosPowerOff, BiosFinished};
      f.len = 4;
      f.nib = {4'h0, rb[3:0], rb[7:4], 4'hF};
      exp_bus.push_back(f);
    end
    if (full && wr && (hit_ctl || hit_sts)) begin
      if (hit_ctl) begin
        m_bios = data;
        exp_wr.push_back(data);
      end else if (data[2]) begin
        m_swap = 1'b0;
      end
      f.len = 2;
      f.nib = 16'h000F;
      exp_bus.push_back(f);
    end
    if (full && swap_at_commit) m_swap = 1'b1;

    for (int i = 0; i < 13; i++) begin
      fr[i]  = 1'b1;
      nib[i] = 4'hF;
    end
    fr[0]  = 1'b0;
    nib[0] = 4'h0;
    nib[1] = ctype;
    nib[2] = addr[15:12];
    nib[3] = addr[11:8];
    nib[4] = addr[7:4];
    nib[5] = addr[3:0];
    if (!rd) begin
      nib[6] = data[3:0];
      nib[7] = data[7:4];
    end
    for (int i = (skip_start ? 1 : 0); i < 13; i++) begin
      if (i == abort_at) begin
        drive(1'b0, abort_lad);
        break;
      end
      ForceSwap = swap_at_commit && (i == commit_idx);
      drive(fr[i], nib[i]);
      ForceSwap = 1'b0;
      if (i == stop_after) break;
    end
  endtask

  initial begin
    int         kind;
    logic [15:0] a;
    logic [3:0]  ct;
    int          ab;
    rst_n        = 1'b0;
    LFRAMEn      = 1'b1;
    LAD_in       = 4'hF;
    BiosFinished = 1'b0;
    BiosPowerOff = 1'b0;
    ForceSwap    = 1'b0;
    m_bios       = 8'h00;
    m_swap       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_oe", {15'b0, LAD_oe}, 16'h0);
    check("reset_lad", {12'b0, LAD_out}, 16'hF);
    check("reset_reg", {8'b0, BiosRegister}, 16'h0);
    check("reset_strobe", {15'b0, WriteBiosWD}, 16'h0);
    rst_n = 1'b1;

    // Write 0x55 starting in the first cycle after reset release.
    lpc(4'h2, Base, 8'h55, -1, 4'hF, 1'b0, 1'b0, -1);
    check("wr55_reg", {8'b0, BiosRegister}, 16'h0055);
    idle(2);

    // Status read after one swap pulse.
    pulse_swap();
    BiosFinished = 1'b1;
    BiosPowerOff = 1'b0;
    idle(1);
    lpc(4'h0, Base + 16'd1, 8'h00, -1, 4'hF, 1'b0, 1'b0, -1);
    idle(2);

    // Unmapped address and memory-read cycle type.
    lpc(4'h2, 16'h0812, 8'hAA, -1, 4'hF, 1'b0, 1'b0, -1);
    idle(1);
    lpc(4'h4, Base, 8'hAA, -1, 4'hF, 1'b0, 1'b0, -1);
    idle(2);
    check("ignored_reg", {8'b0, BiosRegister}, {8'b0, m_bios});

    // Abort during WDATA1 straight into a new START, then a full write of 0xFF.
    lpc(4'h2, Base, 8'h29, 7, 4'h0, 1'b0, 1'b0, -1);
    lpc(4'h2, Base, 8'hFF, -1, 4'hF, 1'b1, 1'b0, -1);
    check("wrff_reg", {8'b0, BiosRegister}, 16'h00FF);
    idle(2);

    // Swap clear racing a ForceSwap pulse, then a plain clear.
    lpc(4'h2, Base + 16'd1, 8'h04, -1, 4'hF, 1'b0, 1'b1, -1);
    idle(1);
    lpc(4'h0, Base + 16'd1, 8'h00, -1, 4'hF, 1'b0, 1'b0, -1);
    idle(1);
    lpc(4'h2, Base + 16'd1, 8'h04, -1, 4'hF, 1'b0, 1'b0, -1);
    idle(1);
    lpc(4'h0, Base + 16'd1, 8'h00, -1, 4'hF, 1'b0, 1'b0, -1);
    idle(2);

    for (int n = 0; n < 200; n++) begin
      BiosFinished = 1'($urandom_range(0, 1));
      BiosPowerOff = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) pulse_swap();
      kind = $urandom_range(0, 9);
      ct   = (kind < 4) ? 4'h0 : (kind < 8) ? 4'h2 : 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0:       a = Base;
        1:       a = Base + 16'd1;
        2:       a = Base + 16'd2;
        default: a = 16'($urandom);
      endcase
      ab = ($urandom_range(0, 5) == 0) ? $urandom_range(1, (ct == 4'h0) ? 7 : 9) : -1;
      lpc(ct, a, 8'($urandom), ab, 4'hF, 1'b0, 1'b0, -1);
      check("rand_reg", {8'b0, BiosRegister}, {8'b0, m_bios});
      idle($urandom_range(1, 3));
    end

    // Reset landing in RDATA0 of a read.
    lpc(4'h2, Base, 8'h3C, -1, 4'hF, 1'b0, 1'b0, -1);
    idle(1);
    pulse_swap();
    lpc(4'h0, Base, 8'h00, -1, 4'hF, 1'b0, 1'b0, 8);
    check("rdata0_oe", {15'b0, LAD_oe}, 16'h1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_oe", {15'b0, LAD_oe}, 16'h0);
    check("rst_mid_lad", {12'b0, LAD_out}, 16'hF);
    check("rst_mid_reg", {8'b0, BiosRegister}, 16'h0);
    check("rst_mid_strobe", {15'b0, WriteBiosWD}, 16'h0);
    m_bios = 8'h00;
    m_swap = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    lpc(4'h0, Base + 16'd1, 8'h00, -1, 4'hF, 1'b0, 1'b0, -1);
    idle(1);
    lpc(4'h0, Base, 8'h00, -1, 4'hF, 1'b0, 1'b0, -1);
    idle(5);
    check("pending_wr", 16'(exp_wr.size()), 16'h0);
    check("pending_bus", 16'(exp_bus.size()), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
